// File: rtl/fetch_queue.sv
// Instruction fetch unit: issues word fetches to instruction memory and buffers
// the returned words with their PCs in a small FIFO; supports redirects and halt-on-zero.
module fetch_queue #(
  parameter int              AW           = 32,
  parameter int              DEPTH        = 4,
  parameter logic [AW-1:0]   RESET_PC     = AW'(32'h00400000),
  parameter bit              STOP_ON_ZERO = 1'b1
) (
  input  logic          clock,
  input  logic          reset_n,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [31:0]   imem_rdata,
  output logic          inst_valid,
  output logic [31:0]   inst,
  output logic [AW-1:0] inst_pc,
  input  logic          inst_ready,
  input  logic          redir_valid,
  input  logic [AW-1:0] redir_target,
  output logic          halted
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_FLUSH,
    S_HALT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] fetch_pc_q, fetch_pc_d;
  logic [AW-1:0] flush_addr_q, flush_addr_d;

  logic [31:0]   inst_mem [DEPTH];
  logic [AW-1:0] pc_mem   [DEPTH];

  logic          enq;
  logic          deq;
  logic          flush;
  logic          acked;
  logic [AW-1:0] redir_pc;

  assign redir_pc   = redir_target & ~AW'(3);
  assign imem_req   = ((state_q == S_FETCH) && (count_q < CW'(DEPTH))) || (state_q == S_FLUSH);
  // While flushing, the abandoned request's address must stay on the bus until it is acked.
  assign imem_addr  = (state_q == S_FLUSH) ? flush_addr_q : fetch_pc_q;
  assign acked      = imem_req & imem_ack;
  assign inst_valid = (count_q != '0);
  assign inst       = inst_mem[rd_ptr_q];
  assign inst_pc    = pc_mem[rd_ptr_q];
  assign halted     = (state_q == S_HALT);

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    flush_addr_d = flush_addr_q;
    enq          = 1'b0;
    flush        = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (redir_valid) begin
          flush      = 1'b1;
          fetch_pc_d = redir_pc;
          if (imem_req && !imem_ack) begin
            state_d      = S_FLUSH;
            flush_addr_d = fetch_pc_q;
          end
        end else if (acked) begin
          if (STOP_ON_ZERO && (imem_rdata == '0)) begin
            state_d = S_HALT;
          end else begin
            enq        = 1'b1;
            fetch_pc_d = fetch_pc_q + AW'(4);
          end
        end
      end
      S_FLUSH: begin
        if (redir_valid) begin
          flush      = 1'b1;
          fetch_pc_d = redir_pc;
        end
        if (imem_ack) begin
          state_d = S_FETCH;
        end
      end
      S_HALT: begin
        if (redir_valid) begin
          flush      = 1'b1;
          fetch_pc_d = redir_pc;
          state_d    = S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // A redirect empties the queue outright, so it also suppresses any dequeue that edge.
  assign deq = inst_valid & inst_ready & ~flush;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      count_d  = count_q + CW'(enq) - CW'(deq);
      wr_ptr_d = wr_ptr_q + PW'(enq);
      rd_ptr_d = rd_ptr_q + PW'(deq);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fetch_pc_q   <= RESET_PC;
      flush_addr_q <= RESET_PC;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fetch_pc_q   <= fetch_pc_d;
      flush_addr_q <= flush_addr_d;
    end
  end

  // Queue storage carries no reset; entries are only read while counted as valid.
  always_ff @(posedge clock) begin
    if (enq) begin
      inst_mem[wr_ptr_q] <= imem_rdata;
      pc_mem[wr_ptr_q]   <= fetch_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: queue-based reference model checked every cycle, plus
// directed scenarios with literal expectations (including an AW=8 instance).
module tb_fetch_queue;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redir_valid;
  logic [31:0] redir_target;
  logic        halted;
  logic [31:0] zero_addr;

  logic        s_req;
  logic [7:0]  s_addr;
  logic        s_ack;
  logic [31:0] s_rdata;
  logic        s_valid;
  logic [31:0] s_inst;
  logic [7:0]  s_inst_pc;
  logic        s_ready;
  logic        s_redir;
  logic [7:0]  s_target;
  logic        s_halted;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  fetch_queue #(.AW(32), .DEPTH(4), .RESET_PC(32'h00400000), .STOP_ON_ZERO(1'b1)) dut (
    .clock(clock), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .redir_valid(redir_valid), .redir_target(redir_target), .halted(halted)
  );

  fetch_queue #(.AW(8), .DEPTH(2), .RESET_PC(8'h00), .STOP_ON_ZERO(1'b0)) dut_small (
    .clock(clock), .reset_n(reset_n),
    .imem_req(s_req), .imem_addr(s_addr), .imem_ack(s_ack), .imem_rdata(s_rdata),
    .inst_valid(s_valid), .inst(s_inst), .inst_pc(s_inst_pc), .inst_ready(s_ready),
    .redir_valid(s_redir), .redir_target(s_target), .halted(s_halted)
  );

  // Instruction memory contents as seen by the main instance.
  function automatic logic [31:0] mem_fn(input logic [31:0] a, input logic [31:0] z);
    if (a == z) return 32'h0;
    if (a == 32'h00400000) return 32'h20080005;
    if (a == 32'h00400004) return 32'h20090007;
    return 32'hC0DE0000 | {16'h0, a[15:0]};
  endfunction

  always_comb imem_rdata = mem_fn(imem_addr, zero_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of {word, pc}, the next fetch address and a few mode flags.
  typedef struct packed {
    logic [31:0] w;
    logic [31:0] pc;
  } ent_t;

  ent_t        m_q[$];
  bit          m_started;
  bit          m_discard;
  bit          m_halt;
  logic [31:0] m_pc;
  logic [31:0] m_old;

  function automatic bit m_req();
    return m_started && (m_discard || (!m_halt && (m_q.size() < 4)));
  endfunction

  function automatic logic [31:0] m_addr();
    return m_discard ? m_old : m_pc;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_started = 0;
    m_discard = 0;
    m_halt    = 0;
    m_pc      = 32'h00400000;
    m_old     = 32'h00400000;
  endtask

  task automatic model_update();
    bit          req;
    logic [31:0] a;
    req = m_req();
    a   = m_addr();
    if (!m_started) begin
      m_started = 1;
      return;
    end
    if (redir_valid) begin
      m_q.delete();
      if (req && !imem_ack) begin
        m_discard = 1;
        m_old     = a;
      end else begin
        m_discard = 0;
      end
      m_pc   = redir_target & 32'hFFFF_FFFC;
      m_halt = 0;
    end else begin
      if ((m_q.size() > 0) && inst_ready) void'(m_q.pop_front());
      if (req && imem_ack) begin
        if (m_discard) m_discard = 0;
        else if (imem_rdata == 32'h0) m_halt = 1;
        else begin
          m_q.push_back({imem_rdata, m_pc});
          m_pc = m_pc + 32'd4;
        end
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clock or negedge reset_n);
      if (!reset_n) model_reset();
      else model_update();
    end
  end

  always @(negedge clock) begin
    if (reset_n) begin
      check("m_req", {31'h0, imem_req}, {31'h0, m_req()});
      if (m_req()) check("m_addr", imem_addr, m_addr());
      check("m_valid", {31'h0, inst_valid}, {31'h0, (m_q.size() != 0)});
      if (m_q.size() != 0) begin
        check("m_inst", inst, m_q[0].w);
        check("m_inst_pc", inst_pc, m_q[0].pc);
      end
      check("m_halted", {31'h0, halted}, {31'h0, m_halt});
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n      = 1'b0;
    imem_ack     = 1'b0;
    inst_ready   = 1'b0;
    redir_valid  = 1'b0;
    redir_target = 32'h0;
    zero_addr    = 32'h1;
    s_ack        = 1'b1;
    s_rdata      = 32'h0;
    s_ready      = 1'b1;
    s_redir      = 1'b0;
    s_target     = 8'h00;
    step(3);

    $display("[TB] reset state");
    check("rst_req", {31'h0, imem_req}, 32'h0);
    check("rst_addr", imem_addr, 32'h00400000);
    check("rst_valid", {31'h0, inst_valid}, 32'h0);
    check("rst_halted", {31'h0, halted}, 32'h0);
    check("rst_small_addr", {24'h0, s_addr}, 32'h0);

    $display("[TB] stream after reset release");
    reset_n    = 1'b1;
    imem_ack   = 1'b1;
    inst_ready = 1'b1;
    check("idle_req", {31'h0, imem_req}, 32'h0);
    step(1);
    check("first_req", {31'h0, imem_req}, 32'h1);
    check("first_addr", imem_addr, 32'h00400000);
    step(1);
    check("w0_valid", {31'h0, inst_valid}, 32'h1);
    check("w0_inst", inst, 32'h20080005);
    check("w0_pc", inst_pc, 32'h00400000);
    step(1);
    check("w1_inst", inst, 32'h20090007);
    check("w1_pc", inst_pc, 32'h00400004);

    $display("[TB] fill queue with consumer stalled");
    inst_ready   = 1'b0;
    redir_valid  = 1'b1;
    redir_target = 32'h00400000;
    step(1);
    redir_valid = 1'b0;
    check("restart_valid", {31'h0, inst_valid}, 32'h0);
    check("restart_addr", imem_addr, 32'h00400000);
    step(4);
    check("full_req", {31'h0, imem_req}, 32'h0);
    check("full_addr", imem_addr, 32'h00400010);
    check("full_head", inst_pc, 32'h00400000);
    step(2);
    check("full_ack_ignored_req", {31'h0, imem_req}, 32'h0);
    check("full_ack_ignored_head", inst_pc, 32'h00400000);
    inst_ready = 1'b1;
    #1;
    check("deq_same_cycle_req", {31'h0, imem_req}, 32'h0);
    step(1);
    inst_ready = 1'b0;
    check("deq_next_req", {31'h0, imem_req}, 32'h1);
    check("deq_next_addr", imem_addr, 32'h00400010);
    check("deq_next_head", inst_pc, 32'h00400004);
    step(1);
    check("refull_req", {31'h0, imem_req}, 32'h0);
    check("refull_addr", imem_addr, 32'h00400014);

    $display("[TB] redirect with request pending");
    imem_ack     = 1'b0;
    redir_valid  = 1'b1;
    redir_target = 32'h00400000;
    step(1);
    redir_valid = 1'b0;
    check("redir_full_addr", imem_addr, 32'h00400000);
    imem_ack   = 1'b1;
    inst_ready = 1'b1;
    step(2);
    imem_ack = 1'b0;
    step(1);
    check("pend_addr", imem_addr, 32'h00400008);
    redir_valid  = 1'b1;
    redir_target = 32'h00400023;
    step(1);
    redir_valid = 1'b0;
    check("flush_req", {31'h0, imem_req}, 32'h1);
    check("flush_addr", imem_addr, 32'h00400008);
    check("flush_valid", {31'h0, inst_valid}, 32'h0);
    step(1);
    check("flush_hold_addr", imem_addr, 32'h00400008);
    imem_ack = 1'b1;
    step(1);
    check("after_flush_addr", imem_addr, 32'h00400020);
    check("after_flush_valid", {31'h0, inst_valid}, 32'h0);
    step(1);
    check("target_word_pc", inst_pc, 32'h00400020);
    check("target_word", inst, 32'hC0DE0020);

    $display("[TB] redirect with ack in same cycle");
    redir_valid  = 1'b1;
    redir_target = 32'h00400200;
    step(1);
    redir_valid = 1'b0;
    check("same_ack_valid", {31'h0, inst_valid}, 32'h0);
    check("same_ack_addr", imem_addr, 32'h00400200);
    step(1);
    check("same_ack_head_pc", inst_pc, 32'h00400200);
    check("same_ack_head", inst, 32'hC0DE0200);

    $display("[TB] redirect while flushing");
    imem_ack = 1'b0;
    step(1);
    redir_valid  = 1'b1;
    redir_target = 32'h00400300;
    step(1);
    redir_target = 32'h00400401;
    step(1);
    redir_valid = 1'b0;
    check("reflush_addr", imem_addr, 32'h00400204);
    check("reflush_req", {31'h0, imem_req}, 32'h1);
    imem_ack = 1'b1;
    step(1);
    check("reflush_new_addr", imem_addr, 32'h00400400);

    $display("[TB] halt on zero word");
    inst_ready = 1'b0;
    zero_addr  = 32'h00400408;
    step(3);
    check("halt_flag", {31'h0, halted}, 32'h1);
    check("halt_req", {31'h0, imem_req}, 32'h0);
    check("halt_head", inst_pc, 32'h00400400);
    inst_ready = 1'b1;
    step(1);
    check("halt_drain_pc", inst_pc, 32'h00400404);
    step(1);
    check("halt_drained_valid", {31'h0, inst_valid}, 32'h0);
    check("halt_still", {31'h0, halted}, 32'h1);
    redir_valid  = 1'b1;
    redir_target = 32'h00400000;
    step(1);
    redir_valid = 1'b0;
    zero_addr   = 32'h1;
    check("unhalt_flag", {31'h0, halted}, 32'h0);
    check("unhalt_req", {31'h0, imem_req}, 32'h1);
    check("unhalt_addr", imem_addr, 32'h00400000);
    step(1);
    check("unhalt_word", inst, 32'h20080005);

    $display("[TB] asynchronous reset mid-request");
    inst_ready = 1'b0;
    imem_ack   = 1'b0;
    step(1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_req", {31'h0, imem_req}, 32'h0);
    check("arst_addr", imem_addr, 32'h00400000);
    check("arst_valid", {31'h0, inst_valid}, 32'h0);
    step(1);
    reset_n    = 1'b1;
    imem_ack   = 1'b1;
    inst_ready = 1'b1;
    check("arst_idle_req", {31'h0, imem_req}, 32'h0);
    step(1);
    check("arst_first_req", {31'h0, imem_req}, 32'h1);
    check("arst_first_addr", imem_addr, 32'h00400000);
    step(2);

    $display("[TB] AW=8 wrap and zero word with STOP_ON_ZERO=0");
    s_redir  = 1'b1;
    s_target = 8'hFD;
    step(1);
    s_redir = 1'b0;
    check("small_redir_addr", {24'h0, s_addr}, 32'h000000FC);
    check("small_redir_valid", {31'h0, s_valid}, 32'h0);
    step(1);
    check("small_wrap_addr", {24'h0, s_addr}, 32'h0);
    check("small_head_pc", {24'h0, s_inst_pc}, 32'h000000FC);
    check("small_zero_enq", {31'h0, s_valid}, 32'h1);
    check("small_zero_inst", s_inst, 32'h0);
    check("small_not_halted", {31'h0, s_halted}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter AW, 32, PC/address width in bits (>= 8).
REQ-002 Parameter DEPTH, 4, instruction queue entries (power of two, >= 2).
REQ-003 Parameter RESET_PC, 32'h00400000 truncated to AW, first fetch address after reset.
REQ-004 Parameter STOP_ON_ZERO, 1, when 1 an all-zero fetched word halts fetching.
REQ-005 clock  in  1  single clock; all state changes on rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 imem_req  out  1  fetch request to instruction memory.
REQ-008 imem_addr  out  AW  word-aligned fetch address, valid while imem_req=1.
REQ-009 imem_ack  in  1  request completed this cycle; imem_rdata valid.
REQ-010 imem_rdata  in  32  fetched instruction word.
REQ-011 inst_valid  out  1  queue head holds a valid instruction.
REQ-012 inst  out  32  instruction at queue head.
REQ-013 inst_pc  out  AW  address of instruction at queue head.
REQ-014 inst_ready  in  1  consumer accepts head this cycle.
REQ-015 redir_valid  in  1  jump/branch redirect (J, JAL, JR, taken branch) this cycle.
REQ-016 redir_target  in  AW  redirect destination; bits [1:0] forced to 0 internally.
REQ-017 halted  out  1  fetching stopped on zero word.

Function
REQ-018 States: IDLE, FETCH, FLUSH, HALT; IDLE -> FETCH unconditionally on first clock edge after reset release.
REQ-019 imem_req SHALL be 1 in FETCH when (count < DEPTH) and in FLUSH; 0 in IDLE and HALT.
REQ-020 Once imem_req=1, imem_addr SHALL hold stable until the cycle imem_ack=1; at most one request outstanding.
REQ-021 FETCH, ack, no redirect, rdata != 0 or STOP_ON_ZERO=0: enqueue {rdata, fetch_pc}; fetch_pc += 4, wrapping modulo 2^AW.
REQ-022 Latency: word acked in cycle n SHALL appear at head with inst_valid=1 in cycle n+1 when queue was empty; no combinational bypass.
REQ-023 Dequeue on inst_valid & inst_ready; simultaneous enqueue and dequeue leaves count unchanged; order strictly FIFO.
REQ-024 inst_valid = (count != 0); inst/inst_pc are don't-care when inst_valid=0.
REQ-025 Full (count == DEPTH): imem_req=0; a dequeue in the same cycle SHALL NOT assert imem_req until the next cycle.
REQ-026 Redirect (any state except IDLE): queue flushed (count <= 0) and fetch_pc <= {redir_target[AW-1:2], 2'b00} on that edge; redirect takes priority over enqueue/dequeue.
REQ-027 Redirect with imem_req=1 and imem_ack=0: go FLUSH, keep old imem_addr until ack, discard that response, then FETCH at new fetch_pc.
REQ-028 Redirect in the same cycle as imem_ack: response discarded; next state FETCH at target.
REQ-029 Redirect while in FLUSH: update fetch_pc to newest target; remain FLUSH until outstanding ack.
REQ-030 STOP_ON_ZERO=1, FETCH, ack with rdata == 0, no redirect: word not enqueued, fetch_pc unchanged, state HALT, halted=1 next cycle.
REQ-031 HALT: queued entries still drain normally; redirect leaves HALT (halted=0 next cycle), FETCH at target.
REQ-032 imem_ack while imem_req=0 SHALL be ignored.

Reset
REQ-033 reset_n=0 asynchronously forces state IDLE, count 0, fetch_pc RESET_PC, imem_req 0, inst_valid 0, halted 0, imem_addr RESET_PC.
REQ-034 Reset mid-request abandons the outstanding request; memory side is responsible for dropping it.
REQ-035 First imem_req=1 with imem_addr=RESET_PC SHALL occur in the second cycle after reset_n rises.

Verification
REQ-036 Reset release, ack every cycle, inst_ready=1, words 0x20080005,0x20090007 -> inst_pc 0x00400000 then 0x00400004, in order, one per cycle.
REQ-037 inst_ready=0, DEPTH=4, ack every cycle -> exactly 4 enqueues, imem_req=0, imem_addr=0x00400010; one dequeue -> imem_req=1 next cycle.
REQ-038 Redirect to 0x00400023 while request to 0x00400008 pending (ack delayed 3 cycles) -> FLUSH, acked word discarded, next imem_addr=0x00400020, queue empty.
REQ-039 Redirect and ack same cycle -> ack data never appears at inst; next imem_addr = target.
REQ-040 STOP_ON_ZERO=1, third word 0x00000000 -> halted=1, first two words drain, imem_req=0; redirect to 0x00400000 -> halted=0, fetch resumes.
REQ-041 AW=8, fetch_pc 0xFC acked -> next imem_addr 0x00 (wrap).
